// File: rtl/div_pkg.sv
// Shared types and sizing constants for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_CNT_WIDTH     = $clog2(DIV_WIDTH_DEFAULT);

    // Step counter width; floor of one bit so a WIDTH of 1 still gets a counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the arithmetic unit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit A - B as a full_adder chain: B inverted, carry-in 1, cout=1 means no borrow.
module ripple_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;
    assign cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_stage
        full_adder u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] next_quo;

    // The dividend register doubles as the quotient: its MSB shifts into the
    // remainder while the new quotient bit shifts in at the LSB.
    always_comb begin
        shifted  = (part_rem << 1) | {{WIDTH{1'b0}}, dvd_reg[WIDTH-1]};
        next_rem = no_borrow ? trial : shifted;
        next_quo = (dvd_reg << 1) | WIDTH'(no_borrow);
    end

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a   (shifted),
        .b   ({1'b0, dvs_reg}),
        .diff(trial),
        .cout(no_borrow)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            step_cnt  <= '0;
            part_rem  <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        if (Divisor != '0) begin
                            dvd_reg   <= Dividend;
                            dvs_reg   <= Divisor;
                            part_rem  <= '0;
                            step_cnt  <= CW'(WIDTH - 1);
                            DivByZero <= 1'b0;
                            Busy      <= 1'b1;
                            state     <= CALC;
                        end else begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    part_rem <= next_rem;
                    dvd_reg  <= next_quo;
                    if (step_cnt == '0) begin
                        Quotient  <= next_quo;
                        Remainder <= next_rem[WIDTH-1:0];
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        step_cnt <= step_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Iterative unsigned restoring divider, the inverse-direction companion to the Wallace tree multiplier: it divides an N-bit dividend by an N-bit divisor, one quotient bit per clock. Each step's trial subtraction uses a ripple subtractor built from the existing `full_adder` cells. A start/done handshake wraps the datapath so it can sit beside the multiplier in the same arithmetic unit.

## Interface

**Parameters**
- `WIDTH`, default 8: operand, quotient and remainder width.

**Ports**
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `Start`, input, 1: request a divide; sampled only in IDLE or DONE.
- `Dividend`, input, WIDTH: unsigned dividend; sampled on the accepting edge.
- `Divisor`, input, WIDTH: unsigned divisor; sampled on the accepting edge.
- `Busy`, output, 1: high in CALC.
- `Done`, output, 1: one-cycle pulse; results valid this cycle.
- `Quotient`, output, WIDTH: result quotient.
- `Remainder`, output, WIDTH: result remainder.
- `DivByZero`, output, 1: the latched operation had `Divisor == 0`.

## Operation

**State machine:** IDLE, CALC, DONE.
- **IDLE:**
  - If `Start=1` and `Divisor != 0`, latch the operands, clear the partial remainder (WIDTH+1 bits), load the step counter with WIDTH-1, and go to CALC.
  - If `Start=1` and `Divisor == 0`, go straight to DONE with `Quotient` = all ones, `Remainder` = `Dividend`, and `DivByZero` = 1.
- **CALC (one step per cycle):**
  - Shift left (remainder, dividend register) by one bit.
  - Compute the trial value as remainder − {0, divisor} over WIDTH+1 bits.
  - If the trial borrow-out indicates non-negative, remainder takes the trial value and the quotient LSB is 1. Otherwise the remainder is restored and the quotient LSB is 0.
  - When the counter reaches 0, go to DONE. Otherwise decrement the counter.
- **DONE:**
  - `Done` is 1 for exactly this cycle.
  - If `Start=1`, behave exactly as IDLE acceptance (back-to-back operation). Otherwise go to IDLE.
- `Start` during CALC is ignored; it is neither queued nor allowed to corrupt the latched operands.
- `Quotient`, `Remainder` and `DivByZero` hold their last values through IDLE until the next DONE overwrites them.
- `DivByZero` clears on acceptance of a non-zero-divisor operation.
- **Width rules:**
  - The partial remainder is WIDTH+1 bits so the trial subtraction never overflows.
  - `Remainder` output is the low WIDTH bits, and is always less than `Divisor` when `Divisor != 0`.

## Timing

- **Reset:** state IDLE. `Busy`, `Done`, `Quotient`, `Remainder` and `DivByZero` are all 0, and the counter is 0.
- **Mid-operation reset:** `RST` in any state returns to the reset values on the next edge. No `Done` is issued for the aborted operation.
- **Normal latency:** with `Start` sampled at edge t:
  - `Busy` is 1 for cycles t+1 … t+WIDTH.
  - `Done` and valid results appear in cycle t+WIDTH+1.
  - For WIDTH=8 this is 9 cycles.
- **Divide-by-zero latency:** `Done` in cycle t+1, and `Busy` never asserts.
- **Throughput:** one operation per WIDTH+1 cycles, with `Start` held or re-asserted in the DONE cycle.
- **Combinational path:** all outputs are registered. The only combinational path is the WIDTH+1-bit ripple subtractor, which must close within one clock.

## Structure

- **Package `div_pkg`:**
  - `div_state_t` enum {IDLE, CALC, DONE}.
  - `DIV_WIDTH_DEFAULT` = 8.
  - Constant for the counter width, `$clog2(WIDTH)`.
- **Sub-module `ripple_subtractor`:**
  - Parameterised N-bit A − B.
  - Chain of `full_adder` instances with B inverted and carry-in 1.
  - Outputs difference and carry-out; carry-out = 1 means no borrow.
  - Instantiated once with N = WIDTH+1.
- **Top level:** FSM, counter, shift registers and output registers only.

## Test plan

- **Basic divide:** Dividend=100, Divisor=7, Start pulse at edge t.
  - `Busy` is high for 8 cycles.
  - `Done` in cycle t+9 with Q=14, R=2, `DivByZero`=0.
- **Extremes:**
  - 255/1 gives Q=255, R=0.
  - 5/9 gives Q=0, R=5.
  - 255/255 gives Q=1, R=0.
- **Divide by zero:** 200/0.
  - `Done` in cycle t+1 with Q=255, R=200, `DivByZero`=1, and `Busy` never high.
  - A following 10/3 gives Q=3, R=1 with `DivByZero`=0.
- **Back-to-back and ignored Start:**
  - Start 12/4, then hold `Start` with 77/8 through CALC. The 77/8 is ignored until the DONE cycle, where it is accepted.
  - Results: first Done Q=3, R=0. Second Done, 9 cycles later, Q=9, R=5.
- **Reset mid-operation:** start 100/7 and assert `RST` during the 4th CALC cycle.
  - All outputs are 0 on the next cycle and no `Done` appears.
  - A fresh 100/7 then completes normally.
- **Randomised sweep:** all 65536 operand pairs for WIDTH=8, checked against a `/` and `%` model.
